knap_enum_search: RTL and testbench

Exhaustive candidate enumerator and hit collector for the 19-item multi-constraint knapsack checker. Drives one item-selection vector per cycle into the combinational checker and samples its `valid` result in the same cycle. Counts feasible selections, records the first one, and optionally streams every feasible selection downstream over a valid/ready FIFO. It is the sequential wrapper that turns the checker into a complete search.

---
 rtl/knap_pkg.sv | 15 +
 rtl/knap_hit_fifo.sv | 62 ++++++
 rtl/knap_enum_search.sv | 148 ++++++++++++++
 tb/tb_knap_enum_search.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/knap_pkg.sv
// Shared types and constants for the knapsack candidate enumerator.
package knap_pkg;

  localparam int unsigned KNAP_N_ITEMS = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } knap_state_t;

  typedef logic [KNAP_N_ITEMS-1:0] knap_sel_t;

endpackage

// File: rtl/knap_hit_fifo.sv
// Synchronous hit FIFO with flush; a pop never frees space for a same-cycle push.
// Compiled only when KNAP_HIT_FIFO_EN is defined.
`ifdef KNAP_HIT_FIFO_EN
module knap_hit_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  input  logic                         pop,
  output logic                         empty,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

  assign level = wr_q - rd_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_q == rd_q);
  assign head  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_d = rd_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule
`endif

// File: rtl/knap_enum_search.sv
// Exhaustive selection enumerator and hit collector around a combinational checker.
// Optional hit FIFO and hit_* stream ports enabled by KNAP_HIT_FIFO_EN.
module knap_enum_search
  import knap_pkg::*;
#(
  parameter int unsigned N_ITEMS = KNAP_N_ITEMS
`ifdef KNAP_HIT_FIFO_EN
  , parameter int unsigned FIFO_DEPTH = 4
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [N_ITEMS-1:0] sel,
  input  logic               chk_valid,
  output logic               busy,
  output logic               done,
  output logic [N_ITEMS:0]   hit_count,
  output logic               first_hit_found,
  output logic [N_ITEMS-1:0] first_hit_sel
`ifdef KNAP_HIT_FIFO_EN
  , output logic               hit_valid
  , output logic [N_ITEMS-1:0] hit_data
  , input  logic               hit_ready
`endif
);

  localparam int unsigned     CW       = N_ITEMS + 1;
  localparam logic [N_ITEMS-1:0] SEL_LAST = '1;

  knap_state_t        state_q, state_d;
  logic [N_ITEMS-1:0] sel_q, sel_d, first_q, first_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               found_q, found_d, busy_q, busy_d, done_q, done_d;
  logic               stall_c, drained_c, accept_c;

  assign accept_c = (state_q == RUN) && !abort && chk_valid && !stall_c;

`ifdef KNAP_HIT_FIFO_EN
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          push_c, pop_c, flush_c, fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level, level_nxt;

  assign stall_c   = (state_q == RUN) && chk_valid && fifo_full;
  assign push_c    = accept_c;
  assign pop_c     = !fifo_empty && hit_ready;
  assign flush_c   = abort && ((state_q == RUN) || (state_q == DRAIN));
  assign hit_valid = !fifo_empty;
  // Occupancy after this cycle's push/pop decides DONE versus DRAIN.
  assign level_nxt = fifo_level + LW'(push_c) - LW'(pop_c);
  assign drained_c = (level_nxt == '0);

  knap_hit_fifo #(
    .WIDTH (N_ITEMS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_c),
    .push  (push_c),
    .din   (sel_q),
    .full  (fifo_full),
    .pop   (pop_c),
    .empty (fifo_empty),
    .head  (hit_data),
    .level (fifo_level)
  );
`else
  assign stall_c   = 1'b0;
  assign drained_c = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    first_d = first_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_d = RUN;
          sel_d   = '0;
          cnt_d   = '0;
          found_d = 1'b0;
          first_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          sel_d   = '0;
        end else if (!stall_c) begin
          if (accept_c) begin
            cnt_d = cnt_q + CW'(1);
            if (!found_q) begin
              found_d = 1'b1;
              first_d = sel_q;
            end
          end
          if (sel_q == SEL_LAST) begin
            sel_d   = '0;
            state_d = drained_c ? DONE : DRAIN;
          end else begin
            sel_d = sel_q + N_ITEMS'(1);
          end
        end
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
        else if (drained_c) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel             = sel_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign hit_count       = cnt_q;
  assign first_hit_found = found_q;
  assign first_hit_sel   = first_q;

endmodule

// File: tb/tb_knap_enum_search.sv
// Directed and randomized bench for knap_enum_search with a 4-item search space.
module tb_knap_enum_search;

  localparam int unsigned N     = 4;
  localparam int unsigned SPACE = 16;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, chk_valid;
  logic [N-1:0] sel, first_hit_sel;
  logic         busy, done, first_hit_found;
  logic [N:0]   hit_count;
`ifdef KNAP_HIT_FIFO_EN
  logic         hit_valid, hit_ready;
  logic [N-1:0] hit_data;
  int           ready_mode;
  logic [N-1:0] got[$];
`endif

  int               mode;
  logic [SPACE-1:0] tbl;
  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  knap_enum_search #(
    .N_ITEMS (N)
`ifdef KNAP_HIT_FIFO_EN
    , .FIFO_DEPTH (4)
`endif
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .sel             (sel),
    .chk_valid       (chk_valid),
    .busy            (busy),
    .done            (done),
    .hit_count       (hit_count),
    .first_hit_found (first_hit_found),
    .first_hit_sel   (first_hit_sel)
`ifdef KNAP_HIT_FIFO_EN
    , .hit_valid     (hit_valid)
    , .hit_data      (hit_data)
    , .hit_ready     (hit_ready)
`endif
  );

  // Feasibility rule applied to a candidate selection.
  function automatic logic model_hit(input int m, input logic [SPACE-1:0] t, input logic [N-1:0] s);
    case (m)
      0:       return s == N'(5);
      1:       return s[0];
      2:       return s == N'(3);
      default: return t[s];
    endcase
  endfunction

  always_comb chk_valid = model_hit(mode, tbl, sel);

`ifdef KNAP_HIT_FIFO_EN
  always @(negedge clk) if (rst_n && hit_valid && hit_ready) got.push_back(hit_data);
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
`ifdef KNAP_HIT_FIFO_EN
    case (ready_mode)
      0:       hit_ready = 1'b0;
      1:       hit_ready = 1'b1;
      default: hit_ready = 1'($urandom_range(0, 1));
    endcase
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_sel(input int target, input string tag);
    int c;
    c = 0;
    while (int'(sel) != target && c < 100) begin
      step();
      c++;
    end
    check(tag, 32'(c < 100), 32'd1);
  endtask

  // Full search from start to done, compared with the set of feasible selections.
  task automatic run_search(input bit exact_sel, input string tag);
    int          cyc, exp_cnt, exp_first;
    logic [N-1:0] exp_q[$];
    exp_cnt   = 0;
    exp_first = 0;
    for (int k = 0; k < int'(SPACE); k++) begin
      if (model_hit(mode, tbl, N'(k))) begin
        if (exp_cnt == 0) exp_first = k;
        exp_cnt++;
        exp_q.push_back(N'(k));
      end
    end
`ifdef KNAP_HIT_FIFO_EN
    got.delete();
`endif
    pulse_start();
    check({tag, "_start_sel"}, 32'(sel), 32'd0);
    check({tag, "_start_cnt"}, 32'(hit_count), 32'd0);
    check({tag, "_start_found"}, 32'(first_hit_found), 32'd0);
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 400) begin
      if (exact_sel && cyc < int'(SPACE)) check({tag, "_sel_seq"}, 32'(sel), 32'(cyc));
      step();
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
`ifndef KNAP_HIT_FIFO_EN
    check({tag, "_done_latency"}, 32'(cyc), 32'(SPACE));
`endif
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_sel_end"}, 32'(sel), 32'd0);
    check({tag, "_count"}, 32'(hit_count), 32'(exp_cnt));
    check({tag, "_found"}, 32'(first_hit_found), 32'(exp_cnt != 0));
    check({tag, "_first"}, 32'(first_hit_sel), 32'(exp_first));
`ifdef KNAP_HIT_FIFO_EN
    check({tag, "_fifo_n"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check({tag, "_fifo_data"}, 32'(got[i]), 32'(exp_q[i]));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    tbl   = '0;
`ifdef KNAP_HIT_FIFO_EN
    ready_mode = 1;
    hit_ready  = 1'b1;
`endif
    #12;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(hit_count), 32'd0);
    check("rst_found", 32'(first_hit_found), 32'd0);
    check("rst_first", 32'(first_hit_sel), 32'd0);
`ifdef KNAP_HIT_FIFO_EN
    check("rst_hit_valid", 32'(hit_valid), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    mode = 0;
    run_search(1'b1, "single_hit");
    mode = 1;
    run_search(1'b1, "odd_hits");

`ifdef KNAP_HIT_FIFO_EN
    // Backpressure: four hits fill the FIFO, the fifth stalls enumeration.
    begin
      logic saw_drain;
      int   c;
      mode = 1;
      ready_mode = 0;
      hit_ready  = 1'b0;
      got.delete();
      pulse_start();
      for (int i = 0; i < 20; i++) step();
      check("stall_sel", 32'(sel), 32'd9);
      check("stall_count", 32'(hit_count), 32'd4);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_hit_valid", 32'(hit_valid), 32'd1);
      ready_mode = 1;
      saw_drain  = 1'b0;
      c = 0;
      while (!done && c < 200) begin
        step();
        if (busy && sel == '0) saw_drain = 1'b1;
        c++;
      end
      check("stall_done", 32'(done), 32'd1);
      check("stall_drain", 32'(saw_drain), 32'd1);
      check("stall_final_count", 32'(hit_count), 32'd8);
      check("stall_fifo_n", 32'(got.size()), 32'd8);
      for (int i = 0; i < 8 && i < got.size(); i++)
        check("stall_fifo_data", 32'(got[i]), 32'(2 * i + 1));
    end
`endif

    // Abort mid-search keeps counters, clears sel and FIFO.
    mode = 2;
    pulse_start();
    wait_sel(6, "abort_reach");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_count", 32'(hit_count), 32'd1);
    check("abort_first", 32'(first_hit_sel), 32'd3);
`ifdef KNAP_HIT_FIFO_EN
    check("abort_fifo_empty", 32'(hit_valid), 32'd0);
`endif

    // start while running must not restart.
    mode = 0;
    pulse_start();
    wait_sel(5, "rerun_reach");
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored_sel", 32'(sel), 32'd6);
    check("start_ignored_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // abort outranks start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_sel", 32'(sel), 32'd0);

    // Asynchronous reset mid-search.
    mode = 1;
    pulse_start();
    wait_sel(10, "reset_reach");
    rst_n = 1'b0;
    #1;
    check("areset_sel", 32'(sel), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_count", 32'(hit_count), 32'd0);
    check("areset_found", 32'(first_hit_found), 32'd0);
    check("areset_first", 32'(first_hit_sel), 32'd0);
`ifdef KNAP_HIT_FIFO_EN
    check("areset_hit_valid", 32'(hit_valid), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Random feasibility tables, back-to-back restarts from DONE.
    mode = 3;
    for (int r = 0; r < 5; r++) begin
      tbl = SPACE'($urandom);
`ifdef KNAP_HIT_FIFO_EN
      ready_mode = 2;
`endif
      run_search(1'b0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
